// File: rtl/cache_mem_pkg.sv
// Shared types and size helpers for the cache-to-memory bridge.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FWD   = 2'd2,
        DRAIN = 2'd3
    } bridge_state_e;

    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 32;
    localparam int unsigned DEFAULT_LINE_WIDTH    = 256;

    // Buffered write-back line: base address plus full line payload.
    typedef struct packed {
        logic [DEFAULT_ADDRESS_WIDTH-1:0] lineBase;
        logic [DEFAULT_LINE_WIDTH-1:0]    lineData;
    } wb_entry_t;

    function automatic int unsigned beatCount(input int unsigned blockSize,
                                              input int unsigned memWidth);
        return (8 * blockSize) / memWidth;
    endfunction

    function automatic int unsigned indexWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_mem_bridge_wb_buffer.sv
// Circular write-back FIFO with a combinational youngest-entry line lookup.
module wb_buffer
    import cache_mem_pkg::*;
#(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned LINE_WIDTH    = 256,
    parameter type         ENTRY_T       = wb_entry_t,
    localparam int unsigned COUNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  ENTRY_T                   pushEntry,
    input  logic                     pop,
    output ENTRY_T                   head,
    output logic [COUNT_WIDTH-1:0]   count,
    input  logic [ADDRESS_WIDTH-1:0] matchAddress,
    output logic                     matchHit_c,
    output logic [LINE_WIDTH-1:0]    matchData_c
);

    localparam int unsigned PTR_WIDTH = indexWidth(DEPTH);

    ENTRY_T                 entries [DEPTH];
    logic [PTR_WIDTH-1:0]   headPtr;
    logic [PTR_WIDTH-1:0]   tailPtr;
    logic [COUNT_WIDTH-1:0] countQ;
    logic                   doPush;
    logic                   doPop;

    function automatic logic [PTR_WIDTH-1:0] nextPtr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign doPush = push && (countQ < COUNT_WIDTH'(DEPTH));
    assign doPop  = pop && (countQ != '0);
    assign head   = entries[headPtr];
    assign count  = countQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            countQ  <= '0;
        end else begin
            if (doPush) tailPtr <= nextPtr(tailPtr);
            if (doPop)  headPtr <= nextPtr(headPtr);
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + COUNT_WIDTH'(1);
                2'b01:   countQ <= countQ - COUNT_WIDTH'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (doPush) entries[tailPtr] <= pushEntry;
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        matchHit_c  = 1'b0;
        matchData_c = entries[headPtr].lineData;
        for (int unsigned age = 0; age < DEPTH; age++) begin
            if ((age < 32'(countQ)) &&
                (entries[PTR_WIDTH'((32'(headPtr) + age) % DEPTH)].lineBase == matchAddress)) begin
                matchHit_c  = 1'b1;
                matchData_c = entries[PTR_WIDTH'((32'(headPtr) + age) % DEPTH)].lineData;
            end
        end
    end

endmodule

// File: rtl/cache_mem_bridge.sv
// Splits whole-line fills and write-backs into memory beats, with a
// write-back buffer that can also serve fills that hit a pending line.
module cache_mem_bridge
    import cache_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned BLOCK_SIZE    = 32,
    parameter int unsigned MEM_WIDTH     = 64,
    parameter int unsigned WB_DEPTH      = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               fillReq,
    input  logic [ADDRESS_WIDTH-1:0]           fillAddress,
    output logic                               fillReady,
    output logic                               fillValid,
    output logic [8*BLOCK_SIZE-1:0]            fillData,
    input  logic                               wbReq,
    input  logic [ADDRESS_WIDTH-1:0]           wbAddress,
    input  logic [8*BLOCK_SIZE-1:0]            wbData,
    output logic                               wbReady,
    output logic [$clog2(WB_DEPTH+1)-1:0]      wbCount,
    output logic                               memReq,
    output logic                               memWrite,
    output logic [ADDRESS_WIDTH-1:0]           memAddress,
    output logic [MEM_WIDTH-1:0]               memWriteData,
    input  logic                               memAck,
    input  logic [MEM_WIDTH-1:0]               memReadData
);

    localparam int unsigned LINE_WIDTH  = 8 * BLOCK_SIZE;
    localparam int unsigned BEATS       = beatCount(BLOCK_SIZE, MEM_WIDTH);
    localparam int unsigned BEAT_WIDTH  = indexWidth(BEATS);
    localparam int unsigned BEAT_BYTES  = MEM_WIDTH / 8;
    localparam int unsigned COUNT_WIDTH = $clog2(WB_DEPTH + 1);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] lineBase;
        logic [LINE_WIDTH-1:0]    lineData;
    } entry_t;

    function automatic logic [ADDRESS_WIDTH-1:0] lineBaseOf(input logic [ADDRESS_WIDTH-1:0] a);
        return a & ~ADDRESS_WIDTH'(BLOCK_SIZE - 1);
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] beatAddress(input logic [ADDRESS_WIDTH-1:0] base,
                                                             input logic [BEAT_WIDTH-1:0]    beat);
        return base + ADDRESS_WIDTH'(32'(beat) * BEAT_BYTES);
    endfunction

    bridge_state_e             stateQ, stateD;
    logic [BEAT_WIDTH-1:0]     beatQ, beatD;
    logic [ADDRESS_WIDTH-1:0]  fillBaseQ, fillBaseD;
    logic [LINE_WIDTH-1:0]     lineBufQ, lineBufD;
    logic                      memReqD;
    logic                      memWriteD;
    logic [ADDRESS_WIDTH-1:0]  memAddressD;
    logic [MEM_WIDTH-1:0]      memWriteDataD;
    logic                      fillValidD;
    logic [LINE_WIDTH-1:0]     fillDataD;

    logic                      wbPop_c;
    entry_t                    wbHead;
    entry_t                    wbPushEntry;
    logic                      matchHit_c;
    logic [LINE_WIDTH-1:0]     matchData_c;
    logic                      beatAck_c;
    logic                      lastBeat_c;
    logic [BEAT_WIDTH-1:0]     nextBeat_c;

    assign wbPushEntry = '{lineBase: lineBaseOf(wbAddress), lineData: wbData};

    wb_buffer #(
        .DEPTH         (WB_DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LINE_WIDTH    (LINE_WIDTH),
        .ENTRY_T       (entry_t)
    ) wbBuffer (
        .clk          (clk),
        .reset        (reset),
        .push         (wbReq),
        .pushEntry    (wbPushEntry),
        .pop          (wbPop_c),
        .head         (wbHead),
        .count        (wbCount),
        .matchAddress (lineBaseOf(fillAddress)),
        .matchHit_c   (matchHit_c),
        .matchData_c  (matchData_c)
    );

    assign fillReady  = (stateQ == IDLE);
    assign wbReady    = (wbCount < COUNT_WIDTH'(WB_DEPTH));
    assign beatAck_c  = memReq && memAck;
    assign lastBeat_c = (beatQ == BEAT_WIDTH'(BEATS - 1));
    assign nextBeat_c = lastBeat_c ? '0 : beatQ + BEAT_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ       <= IDLE;
            beatQ        <= '0;
            fillBaseQ    <= '0;
            lineBufQ     <= '0;
            memReq       <= 1'b0;
            memWrite     <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            fillValid    <= 1'b0;
            fillData     <= '0;
        end else begin
            stateQ       <= stateD;
            beatQ        <= beatD;
            fillBaseQ    <= fillBaseD;
            lineBufQ     <= lineBufD;
            memReq       <= memReqD;
            memWrite     <= memWriteD;
            memAddress   <= memAddressD;
            memWriteData <= memWriteDataD;
            fillValid    <= fillValidD;
            fillData     <= fillDataD;
        end
    end

    // Next-state and next-register values; a started burst always runs to its final ack.
    always_comb begin
        stateD        = stateQ;
        beatD         = beatQ;
        fillBaseD     = fillBaseQ;
        lineBufD      = lineBufQ;
        memReqD       = memReq;
        memWriteD     = memWrite;
        memAddressD   = memAddress;
        memWriteDataD = memWriteData;
        fillValidD    = 1'b0;
        fillDataD     = fillData;
        wbPop_c       = 1'b0;

        case (stateQ)
            IDLE: begin
                if (fillReq) begin
                    if (matchHit_c) begin
                        stateD     = FWD;
                        fillDataD  = matchData_c;
                        fillValidD = 1'b1;
                    end else begin
                        stateD        = FILL;
                        beatD         = '0;
                        fillBaseD     = lineBaseOf(fillAddress);
                        memReqD       = 1'b1;
                        memWriteD     = 1'b0;
                        memAddressD   = lineBaseOf(fillAddress);
                        memWriteDataD = '0;
                    end
                end else if (wbCount != '0) begin
                    stateD        = DRAIN;
                    beatD         = '0;
                    memReqD       = 1'b1;
                    memWriteD     = 1'b1;
                    memAddressD   = wbHead.lineBase;
                    memWriteDataD = wbHead.lineData[0 +: MEM_WIDTH];
                end
            end

            FILL: begin
                if (beatAck_c) begin
                    lineBufD[32'(beatQ) * MEM_WIDTH +: MEM_WIDTH] = memReadData;
                    beatD = nextBeat_c;
                    if (lastBeat_c) begin
                        stateD     = IDLE;
                        memReqD    = 1'b0;
                        fillValidD = 1'b1;
                        fillDataD  = lineBufD;
                    end else begin
                        memAddressD = beatAddress(fillBaseQ, nextBeat_c);
                    end
                end
            end

            FWD: begin
                stateD = IDLE;
            end

            DRAIN: begin
                if (beatAck_c) begin
                    beatD = nextBeat_c;
                    if (lastBeat_c) begin
                        stateD    = IDLE;
                        memReqD   = 1'b0;
                        memWriteD = 1'b0;
                        wbPop_c   = 1'b1;
                    end else begin
                        memAddressD   = beatAddress(wbHead.lineBase, nextBeat_c);
                        memWriteDataD = wbHead.lineData[32'(nextBeat_c) * MEM_WIDTH +: MEM_WIDTH];
                    end
                end
            end

            default: stateD = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Scoreboard bench for cache_mem_bridge: stimulus queues expected beats and
// lines, an independent monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_cache_mem_bridge;

    localparam int unsigned AW    = 32;
    localparam int unsigned BS    = 32;
    localparam int unsigned MW    = 64;
    localparam int unsigned WBD   = 2;
    localparam int unsigned LW    = 8 * BS;
    localparam int unsigned BEATS = 4;
    localparam int unsigned CW    = $clog2(WBD + 1);
    localparam int          LIMIT = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          fillReq;
    logic [AW-1:0] fillAddress;
    logic          fillReady;
    logic          fillValid;
    logic [LW-1:0] fillData;
    logic          wbReq;
    logic [AW-1:0] wbAddress;
    logic [LW-1:0] wbData;
    logic          wbReady;
    logic [CW-1:0] wbCount;
    logic          memReq;
    logic          memWrite;
    logic [AW-1:0] memAddress;
    logic [MW-1:0] memWriteData;
    logic          memAck;
    logic [MW-1:0] memReadData;

    cache_mem_bridge #(
        .ADDRESS_WIDTH (AW),
        .BLOCK_SIZE    (BS),
        .MEM_WIDTH     (MW),
        .WB_DEPTH      (WBD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fillReq      (fillReq),
        .fillAddress  (fillAddress),
        .fillReady    (fillReady),
        .fillValid    (fillValid),
        .fillData     (fillData),
        .wbReq        (wbReq),
        .wbAddress    (wbAddress),
        .wbData       (wbData),
        .wbReady      (wbReady),
        .wbCount      (wbCount),
        .memReq       (memReq),
        .memWrite     (memWrite),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memAck       (memAck),
        .memReadData  (memReadData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [MW-1:0] data;
    } mem_exp_t;

    mem_exp_t      expMemQ[$];
    logic [LW-1:0] expFillQ[$];
    logic [MW-1:0] rdQ[$];
    int            ackBudget;
    int            vectors;
    int            miscompares;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out after %0d cycles", name, LIMIT);
    endtask

    function automatic logic [LW-1:0] wbLine(input logic [7:0] tag);
        logic [LW-1:0] l;
        for (int k = 0; k < BEATS; k++)
            l[k*MW +: MW] = {24'hC0FFEE, tag, 24'h000000, tag + 8'(k)};
        return l;
    endfunction

    task automatic expectReads(input logic [AW-1:0] base, input logic [7:0] tag);
        logic [LW-1:0] l;
        for (int k = 0; k < BEATS; k++) begin
            rdQ.push_back(MW'(tag + 8'(k)));
            expMemQ.push_back('{write: 1'b0, addr: base + AW'(8 * k), data: '0});
            l[k*MW +: MW] = MW'(tag + 8'(k));
        end
        expFillQ.push_back(l);
    endtask

    task automatic expectDrain(input logic [AW-1:0] base, input logic [LW-1:0] line);
        for (int k = 0; k < BEATS; k++)
            expMemQ.push_back('{write: 1'b1, addr: base + AW'(8 * k), data: line[k*MW +: MW]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWb(input logic [AW-1:0] a, input logic [LW-1:0] d);
        wbReq = 1'b1; wbAddress = a; wbData = d;
        tick();
        wbReq = 1'b0;
    endtask

    task automatic issueFill(input logic [AW-1:0] a);
        int n = 0;
        while (!fillReady && n < LIMIT) begin tick(); n++; end
        if (n >= LIMIT) timeout("fillReady wait");
        fillReq = 1'b1; fillAddress = a;
        tick();
        fillReq = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (!(fillReady && !memReq && wbCount == '0) && n < LIMIT) begin tick(); n++; end
        if (n >= LIMIT) timeout(name);
    endtask

    // Memory model: acks in the same cycle a beat is presented, within the ack budget.
    initial begin
        memAck = 1'b0;
        memReadData = '0;
        forever begin
            tick();
            if (memReq && ackBudget != 0) begin
                memAck = 1'b1;
                if (ackBudget > 0) ackBudget--;
                memReadData = (!memWrite && rdQ.size() > 0) ? rdQ.pop_front() : '0;
            end else begin
                memAck = 1'b0;
                memReadData = '0;
            end
        end
    end

    // Monitor: completed beats and delivered lines against the scoreboard queues.
    initial begin
        logic          prevPend;
        logic          prevWrite;
        logic [AW-1:0] prevAddr;
        logic [MW-1:0] prevData;
        mem_exp_t      e;
        logic [LW-1:0] l;
        prevPend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevPend = 1'b0;
                continue;
            end
            if (prevPend) begin
                check("memReq held", LW'(memReq), LW'(1'b1));
                check("memWrite stable", LW'(memWrite), LW'(prevWrite));
                check("memAddress stable", LW'(memAddress), LW'(prevAddr));
                check("memWriteData stable", LW'(memWriteData), LW'(prevData));
            end
            if (memReq && memAck) begin
                if (expMemQ.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected beat: write=%0b addr=%0h, none expected", memWrite, memAddress);
                end else begin
                    e = expMemQ.pop_front();
                    check("beat direction", LW'(memWrite), LW'(e.write));
                    check("beat address", LW'(memAddress), LW'(e.addr));
                    if (e.write) check("beat write data", LW'(memWriteData), LW'(e.data));
                end
            end
            if (fillValid) begin
                if (expFillQ.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected fillValid: fillData=%0h, none expected", fillData);
                end else begin
                    l = expFillQ.pop_front();
                    check("fillData", fillData, l);
                end
            end
            prevPend  = memReq && !memAck;
            prevWrite = memWrite;
            prevAddr  = memAddress;
            prevData  = memWriteData;
        end
    end

    always @(posedge clk) begin
        if (!reset)
            assert (!(fillReq && fillReady && wbReq && wbReady &&
                      (fillAddress[AW-1:5] == wbAddress[AW-1:5])))
                else $error("protocol violation: same-line push and fill in one cycle");
    end

    initial begin
        int lat;
        int waited;
        vectors = 0; miscompares = 0;
        reset = 1'b1; fillReq = 1'b0; fillAddress = '0;
        wbReq = 1'b0; wbAddress = '0; wbData = '0; ackBudget = -1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset fillReady", LW'(fillReady), LW'(1'b1));
        check("reset wbReady", LW'(wbReady), LW'(1'b1));
        check("reset memReq", LW'(memReq), LW'(1'b0));
        check("reset memWrite", LW'(memWrite), LW'(1'b0));
        check("reset memAddress", LW'(memAddress), '0);
        check("reset wbCount", LW'(wbCount), '0);
        check("reset fillValid", LW'(fillValid), '0);
        check("reset fillData", fillData, '0);

        // Fill miss with immediate acks.
        expectReads(32'h1000_0000, 8'hA0);
        issueFill(32'h1000_0014);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!fillValid && lat < 20);
        check("fill miss latency", LW'(lat), LW'(BEATS + 1));
        check("fill line A3..A0", fillData, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        @(negedge clk);
        check("fillValid one cycle", LW'(fillValid), LW'(1'b0));
        waitIdle("idle after fill");

        // Fill the buffer while the drain is stalled; a third push is refused.
        ackBudget = 0;
        expectDrain(32'h2000, wbLine(8'h20));
        expectDrain(32'h3000, wbLine(8'h30));
        pushWb(32'h2000, wbLine(8'h20));
        pushWb(32'h3000, wbLine(8'h30));
        check("full wbCount", LW'(wbCount), LW'(2));
        check("full wbReady", LW'(wbReady), LW'(1'b0));
        pushWb(32'h5000, wbLine(8'h50));
        check("refused push wbCount", LW'(wbCount), LW'(2));
        check("stalled drain memReq", LW'(memReq), LW'(1'b1));
        check("stalled drain memWrite", LW'(memWrite), LW'(1'b1));
        check("stalled drain address", LW'(memAddress), LW'(32'h2000));
        ackBudget = -1;
        lat = 0;
        while (wbCount != CW'(1) && lat < LIMIT) begin tick(); lat++; end
        if (lat >= LIMIT) timeout("first drain pop");
        check("wbReady after pop", LW'(wbReady), LW'(1'b1));
        waitIdle("idle after drains");

        // Fill hitting a buffered line is forwarded without a read burst.
        expFillQ.push_back(wbLine(8'h40));
        expectDrain(32'h4000, wbLine(8'h40));
        pushWb(32'h4000, wbLine(8'h40));
        issueFill(32'h4008);
        @(negedge clk);
        check("hit fillValid next cycle", LW'(fillValid), LW'(1'b1));
        check("hit no memReq", LW'(memReq), LW'(1'b0));
        waitIdle("idle after forward");

        // Fill beats a pending drain; a fill during the drain waits for its final ack.
        expectReads(32'h7000, 8'hB0);
        expectDrain(32'h6000, wbLine(8'h60));
        expectReads(32'h8000, 8'hC0);
        wbReq = 1'b1; wbAddress = 32'h6000; wbData = wbLine(8'h60);
        fillReq = 1'b1; fillAddress = 32'h7000;
        tick();
        wbReq = 1'b0; fillReq = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!(memReq && memWrite) && lat < LIMIT);
        if (lat >= LIMIT) timeout("drain start");
        fillReq = 1'b1; fillAddress = 32'h8000;
        waited = 0;
        while (!fillReady && waited < LIMIT) begin @(negedge clk); waited++; end
        if (waited >= LIMIT) timeout("fill behind drain");
        check("fill held during drain", LW'(waited), LW'(BEATS));
        check("drain popped before fill", LW'(wbCount), '0);
        @(posedge clk);
        #1 fillReq = 1'b0;
        waitIdle("idle after fill behind drain");

        // Reset during beat 2 of a fill with acks withheld.
        ackBudget = 2;
        rdQ.push_back(64'hE0);
        rdQ.push_back(64'hE1);
        expMemQ.push_back('{write: 1'b0, addr: 32'h9000, data: '0});
        expMemQ.push_back('{write: 1'b0, addr: 32'h9008, data: '0});
        wbReq = 1'b1; wbAddress = 32'hA000; wbData = wbLine(8'hA0);
        fillReq = 1'b1; fillAddress = 32'h9000;
        tick();
        wbReq = 1'b0; fillReq = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!(memReq && memAddress == 32'h9010) && lat < LIMIT);
        if (lat >= LIMIT) timeout("beat 2 stall");
        check("buffered before reset", LW'(wbCount), LW'(1));
        #2 reset = 1'b1;
        #1;
        check("reset drops memReq", LW'(memReq), LW'(1'b0));
        check("reset empties buffer", LW'(wbCount), '0);
        check("reset no fillValid", LW'(fillValid), LW'(1'b0));
        check("reset clears fillData", fillData, '0);
        check("reset fillReady", LW'(fillReady), LW'(1'b1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ackBudget = -1;
        expectReads(32'h0000_B000, 8'hF0);
        issueFill(32'h0000_B010);
        waitIdle("idle after post-reset fill");

        repeat (10) tick();
        check("beats left unseen", LW'(expMemQ.size()), '0);
        check("fills left unseen", LW'(expFillQ.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
